decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL use one clock, clk; reset is asynchronous and active-low (port reset, asserted at 0).
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, value loaded into IF/ID on reset/flush.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  async active-low reset.
REQ-005 E  in  1  IF/ID load enable (0 = stall/hold).
REQ-006 S  in  1  hazard bubble select; 1 forces all control outputs to 0.
REQ-007 instr_in  in  32  fetched instruction.
REQ-008 next_pc  in  32  PC value accompanying instr_in.
REQ-009 NZCV  in  4  condition flags {N,Z,C,V}.
REQ-010 instr_out  out  32  IF/ID instruction register.
REQ-011 Next_PC  out  32  IF/ID PC register.
REQ-012 instr_i23_i0  out  24  instr_out[23:0] (branch offset).
REQ-013 instr_i3_i0  out  4  instr_out[3:0] (Rm).
REQ-014 instr_i19_i16  out  4  instr_out[19:16] (Rn).
REQ-015 instr_i15_i12  out  4  instr_out[15:12] (Rd).
REQ-016 instr_i11_i0  out  12  instr_out[11:0] (shifter operand/offset).
REQ-017 instr_i31_i28  out  4  instr_out[31:28] (condition).
REQ-018 ALU_OP  out  4  ALU operation.
REQ-019 ID_AM  out  2  addressing mode: 00 rotated imm32, 01 shifted register, 10 imm12 offset, 11 register offset.
REQ-020 ID_LOAD / ID_MEM_WRITE / ID_MEM_SIZE / ID_MEM_E  out  1 each  load, store, byte size, memory enable.
REQ-021 STORE_CC  out  1  update flags.
REQ-022 RF_E  out  1  register-file write enable.
REQ-023 ID_B / ID_BL  out  1 each  branch / branch-with-link decoded.
REQ-024 Branched  out  1  taken branch; EX_BL_instr  out  1  taken BL.

Function
REQ-025 IF/ID: on rising clk with E=1, instr_out<=instr_in and Next_PC<=next_pc; with E=0, hold.
REQ-026 Decode is combinational from instr_out (control valid 1 cycle after instr_in sampled); instr_out==0 decodes as NOP (all control 0).
REQ-027 instr[27:25]=000/001: data processing; ALU_OP=instr[24:21], STORE_CC=instr[20], ID_AM=01/00, RF_E=1 except ALU_OP 1000-1011 (TST/TEQ/CMP/CMN) => 0.
REQ-028 instr[27:25]=010/011: load/store; ID_MEM_E=1, ID_LOAD=L(bit20), ID_MEM_WRITE=~L, ID_MEM_SIZE=B(bit22), ALU_OP=0100 if U(bit23)=1 else 0010, ID_AM=10/11, RF_E=L, STORE_CC=0.
REQ-029 instr[27:25]=101: ID_B=~instr[24], ID_BL=instr[24], ALU_OP=0, RF_E=0; any other class decodes as NOP.
REQ-030 S=1 zeroes ALU_OP, ID_AM and all 1-bit control outputs, including ID_B/ID_BL; field taps unaffected.
REQ-031 Condition evaluation: 16 ARM codes on instr_i31_i28 and NZCV (EQ,NE,CS,CC,MI,PL,VS,VC,HI,LS,GE,LT,GT,LE; 1110 always true, 1111 never).
REQ-032 Branched=(ID_B|ID_BL)&cond; EX_BL_instr=ID_BL&cond; both combinational.
REQ-033 Priority at clk edge: reset > flush (REQ-037) > E.

Reset
REQ-034 reset=0 asynchronously sets instr_out=NOP_WORD, Next_PC=0; all decode outputs therefore 0; mid-operation assertion takes effect without a clock edge.
REQ-035 Deassertion is synchronized externally; first load occurs on first rising edge after reset=1 with E=1.

Configuration
REQ-036 Macro BRANCH_FLUSH_EN selects branch flush.
REQ-037 Defined: Branched=1 at a rising edge loads NOP_WORD into instr_out (Next_PC loads normally) regardless of E; undefined: IF/ID follows REQ-025 only (delay slot).

Structure
REQ-038 Package decode_pkg holds condition-code, ALU opcode, instruction-class and ID_AM constants.
REQ-039 One sub-module cond_eval (instr_i31_i28, NZCV -> cond); remainder in decode_stage.

Verification
REQ-040 instr_in=32'hE0821003, E=1, edge -> ALU_OP=0100, ID_AM=01, RF_E=1, STORE_CC=0, instr_i19_i16=2, instr_i15_i12=1, instr_i3_i0=3.
REQ-041 32'hE5921004 -> ID_LOAD=1, ID_MEM_E=1, ID_MEM_WRITE=0, ID_MEM_SIZE=0, ALU_OP=0100, ID_AM=10, RF_E=1.
REQ-042 32'hE3510000 -> ALU_OP=1010, STORE_CC=1, RF_E=0, ID_AM=00; same with S=1 -> all control 0.
REQ-043 32'h0A000002: NZCV=0100 -> Branched=1; NZCV=0000 -> Branched=0; 32'hEB000005 -> ID_BL=1, EX_BL_instr=1, next edge instr_out=0 (flush build).
REQ-044 E=0 for 3 edges with changing instr_in -> instr_out/Next_PC hold; reset=0 mid-cycle -> instr_out=0 immediately.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg -- shared constants for the decode stage.
//   cond_e         : ARM condition codes (instr[31:28])
//   alu_op_e       : ARM data-processing opcodes (ALU_OP encoding)
//   instr_class_e  : instruction class from instr[27:25]
//   AM_*           : ID_AM addressing-mode encodings
package decode_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000, COND_NE = 4'b0001, COND_CS = 4'b0010, COND_CC = 4'b0011,
    COND_MI = 4'b0100, COND_PL = 4'b0101, COND_VS = 4'b0110, COND_VC = 4'b0111,
    COND_HI = 4'b1000, COND_LS = 4'b1001, COND_GE = 4'b1010, COND_LT = 4'b1011,
    COND_GT = 4'b1100, COND_LE = 4'b1101, COND_AL = 4'b1110, COND_NV = 4'b1111
  } cond_e;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000, ALU_EOR = 4'b0001, ALU_SUB = 4'b0010, ALU_RSB = 4'b0011,
    ALU_ADD = 4'b0100, ALU_ADC = 4'b0101, ALU_SBC = 4'b0110, ALU_RSC = 4'b0111,
    ALU_TST = 4'b1000, ALU_TEQ = 4'b1001, ALU_CMP = 4'b1010, ALU_CMN = 4'b1011,
    ALU_ORR = 4'b1100, ALU_MOV = 4'b1101, ALU_BIC = 4'b1110, ALU_MVN = 4'b1111
  } alu_op_e;

  typedef enum logic [2:0] {
    CLS_DP_REG = 3'b000,
    CLS_DP_IMM = 3'b001,
    CLS_LS_IMM = 3'b010,
    CLS_LS_REG = 3'b011,
    CLS_BRANCH = 3'b101
  } instr_class_e;

  localparam logic [1:0] AM_IMM32  = 2'b00;  // rotated immediate
  localparam logic [1:0] AM_SHREG  = 2'b01;  // shifted register
  localparam logic [1:0] AM_IMM12  = 2'b10;  // 12-bit immediate offset
  localparam logic [1:0] AM_REGOFF = 2'b11;  // register offset

endpackage

// File: rtl/decode_stage_cond_eval.sv
// cond_eval -- ARM condition-code evaluator.
//   instr_i31_i28 : condition field of the instruction in IF/ID
//   NZCV          : flags {N,Z,C,V}
//   cond          : 1 when the condition passes
module cond_eval
  import decode_pkg::*;
(
  input  logic [3:0] instr_i31_i28,
  input  logic [3:0] NZCV,
  output logic       cond
);

  logic n, z, c, v;
  assign {n, z, c, v} = NZCV;

  always_comb begin
    cond = 1'b0;
    case (cond_e'(instr_i31_i28))
      COND_EQ: cond = z;
      COND_NE: cond = ~z;
      COND_CS: cond = c;
      COND_CC: cond = ~c;
      COND_MI: cond = n;
      COND_PL: cond = ~n;
      COND_VS: cond = v;
      COND_VC: cond = ~v;
      COND_HI: cond = c & ~z;
      COND_LS: cond = ~c | z;
      COND_GE: cond = (n == v);
      COND_LT: cond = (n != v);
      COND_GT: cond = ~z & (n == v);
      COND_LE: cond = z | (n != v);
      COND_AL: cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage -- IF/ID pipeline register plus combinational instruction decode.
//   clk, reset (async, active-low)
//   E   : IF/ID load enable (0 = hold)      S : bubble select (zeroes control)
//   instr_in, next_pc, NZCV                 : fetch-side inputs and flags
//   instr_out, Next_PC                      : IF/ID registers
//   instr_i*_i*                             : field taps of instr_out
//   ALU_OP, ID_AM, ID_LOAD, ID_MEM_WRITE, ID_MEM_SIZE, ID_MEM_E,
//   STORE_CC, RF_E, ID_B, ID_BL             : decoded control
//   Branched, EX_BL_instr                   : taken branch / taken BL
// Build option: define BRANCH_FLUSH_EN to replace the instruction behind a
// taken branch with NOP_WORD; otherwise it executes as a delay slot.
module decode_stage
  import decode_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E,
  input  logic        S,
  input  logic [31:0] instr_in,
  input  logic [31:0] next_pc,
  input  logic [3:0]  NZCV,
  output logic [31:0] instr_out,
  output logic [31:0] Next_PC,
  output logic [23:0] instr_i23_i0,
  output logic [3:0]  instr_i3_i0,
  output logic [3:0]  instr_i19_i16,
  output logic [3:0]  instr_i15_i12,
  output logic [11:0] instr_i11_i0,
  output logic [3:0]  instr_i31_i28,
  output logic [3:0]  ALU_OP,
  output logic [1:0]  ID_AM,
  output logic        ID_LOAD,
  output logic        ID_MEM_WRITE,
  output logic        ID_MEM_SIZE,
  output logic        ID_MEM_E,
  output logic        STORE_CC,
  output logic        RF_E,
  output logic        ID_B,
  output logic        ID_BL,
  output logic        Branched,
  output logic        EX_BL_instr
);

  logic cond;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_out <= NOP_WORD;
      Next_PC   <= '0;
    end else begin
`ifdef BRANCH_FLUSH_EN
      if (Branched)
        instr_out <= NOP_WORD;
      else if (E)
        instr_out <= instr_in;
`else
      if (E)
        instr_out <= instr_in;
`endif
      if (E)
        Next_PC <= next_pc;
    end
  end

  assign instr_i23_i0  = instr_out[23:0];
  assign instr_i3_i0   = instr_out[3:0];
  assign instr_i19_i16 = instr_out[19:16];
  assign instr_i15_i12 = instr_out[15:12];
  assign instr_i11_i0  = instr_out[11:0];
  assign instr_i31_i28 = instr_out[31:28];

  // The all-zero word would otherwise decode as AND r0,r0,r0 with RF_E=1;
  // it is treated explicitly as a NOP so the reset/flush value is inert.
  always_comb begin
    ALU_OP       = '0;
    ID_AM        = '0;
    ID_LOAD      = 1'b0;
    ID_MEM_WRITE = 1'b0;
    ID_MEM_SIZE  = 1'b0;
    ID_MEM_E     = 1'b0;
    STORE_CC     = 1'b0;
    RF_E         = 1'b0;
    ID_B         = 1'b0;
    ID_BL        = 1'b0;
    if (instr_out != '0 && !S) begin
      case (instr_class_e'(instr_out[27:25]))
        CLS_DP_REG, CLS_DP_IMM: begin
          ALU_OP   = instr_out[24:21];
          STORE_CC = instr_out[20];
          ID_AM    = instr_out[25] ? AM_IMM32 : AM_SHREG;
          RF_E     = !(instr_out[24:21] inside {ALU_TST, ALU_TEQ, ALU_CMP, ALU_CMN});
        end
        CLS_LS_IMM, CLS_LS_REG: begin
          ID_MEM_E     = 1'b1;
          ID_LOAD      = instr_out[20];
          ID_MEM_WRITE = ~instr_out[20];
          ID_MEM_SIZE  = instr_out[22];
          ALU_OP       = instr_out[23] ? ALU_ADD : ALU_SUB;
          ID_AM        = instr_out[25] ? AM_REGOFF : AM_IMM12;
          RF_E         = instr_out[20];
        end
        CLS_BRANCH: begin
          ID_B  = ~instr_out[24];
          ID_BL = instr_out[24];
        end
        default: ;
      endcase
    end
  end

  cond_eval u_cond_eval (
    .instr_i31_i28 (instr_i31_i28),
    .NZCV          (NZCV),
    .cond          (cond)
  );

  assign Branched    = (ID_B | ID_BL) & cond;
  assign EX_BL_instr = ID_BL & cond;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        E = 1'b0, S = 1'b0;
  logic [31:0] instr_in = '0, next_pc = '0;
  logic [3:0]  NZCV = '0;
  logic [31:0] instr_out, Next_PC;
  logic [23:0] instr_i23_i0;
  logic [3:0]  instr_i3_i0, instr_i19_i16, instr_i15_i12, instr_i31_i28;
  logic [11:0] instr_i11_i0;
  logic [3:0]  ALU_OP;
  logic [1:0]  ID_AM;
  logic        ID_LOAD, ID_MEM_WRITE, ID_MEM_SIZE, ID_MEM_E, STORE_CC, RF_E;
  logic        ID_B, ID_BL, Branched, EX_BL_instr;

  decode_stage #(.NOP_WORD(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .E(E), .S(S), .instr_in(instr_in), .next_pc(next_pc),
    .NZCV(NZCV), .instr_out(instr_out), .Next_PC(Next_PC),
    .instr_i23_i0(instr_i23_i0), .instr_i3_i0(instr_i3_i0),
    .instr_i19_i16(instr_i19_i16), .instr_i15_i12(instr_i15_i12),
    .instr_i11_i0(instr_i11_i0), .instr_i31_i28(instr_i31_i28),
    .ALU_OP(ALU_OP), .ID_AM(ID_AM), .ID_LOAD(ID_LOAD), .ID_MEM_WRITE(ID_MEM_WRITE),
    .ID_MEM_SIZE(ID_MEM_SIZE), .ID_MEM_E(ID_MEM_E), .STORE_CC(STORE_CC), .RF_E(RF_E),
    .ID_B(ID_B), .ID_BL(ID_BL), .Branched(Branched), .EX_BL_instr(EX_BL_instr)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: ARM condition rules written out directly on the flags.
  function automatic logic ref_cond(logic [3:0] c, logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Control vector: {alu[3:0], am[1:0], load, mw, size, me, scc, rfe, b, bl, branched, exbl}
  function automatic logic [17:0] ref_ctrl(logic [31:0] w, logic s, logic [3:0] f);
    logic [3:0] alu = 4'd0;
    logic [1:0] am = 2'd0;
    logic ld = 0, mw = 0, sz = 0, me = 0, scc = 0, rfe = 0, b = 0, bl = 0, tk;
    if (w != 32'd0 && !s) begin
      case (w[27:25])
        3'd0, 3'd1: begin
          alu = w[24:21];
          scc = w[20];
          am  = w[25] ? 2'd0 : 2'd1;
          rfe = !(alu >= 4'd8 && alu <= 4'd11);
        end
        3'd2, 3'd3: begin
          me  = 1; ld = w[20]; mw = !w[20]; sz = w[22];
          alu = w[23] ? 4'd4 : 4'd2;
          am  = w[25] ? 2'd3 : 2'd2;
          rfe = w[20];
        end
        3'd5: begin
          b  = !w[24];
          bl = w[24];
        end
        default: ;
      endcase
    end
    tk = ref_cond(w[31:28], f);
    return {alu, am, ld, mw, sz, me, scc, rfe, b, bl, (b | bl) & tk, bl & tk};
  endfunction

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [17:0] ctrl;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_ir = '0, m_pc = '0;
  logic [17:0] m_ctrl = '0;

  // Monitor: one scoreboard entry is consumed every falling edge it exists for.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("instr_out", {32'd0, instr_out}, {32'd0, e.ir});
      chk("Next_PC", {32'd0, Next_PC}, {32'd0, e.pc});
      chk("field_taps",
          {12'd0, instr_i31_i28, instr_i23_i0, instr_i19_i16, instr_i15_i12, instr_i11_i0, instr_i3_i0},
          {12'd0, e.ir[31:28], e.ir[23:0], e.ir[19:16], e.ir[15:12], e.ir[11:0], e.ir[3:0]});
      chk("control",
          {46'd0, ALU_OP, ID_AM, ID_LOAD, ID_MEM_WRITE, ID_MEM_SIZE, ID_MEM_E, STORE_CC, RF_E,
           ID_B, ID_BL, Branched, EX_BL_instr},
          {46'd0, e.ctrl});
    end
  end

  // Called just after a rising edge: drive inputs and record what the
  // outputs must be before the next rising edge.
  task automatic setup(input logic [31:0] ins, input logic [31:0] pc, input logic e,
                       input logic s, input logic [3:0] f);
    instr_in = ins; next_pc = pc; E = e; S = s; NZCV = f;
    m_ctrl = ref_ctrl(m_ir, s, f);
    sb.push_back('{ir: m_ir, pc: m_pc, ctrl: m_ctrl});
  endtask

  task automatic tick();
    @(posedge clk);
`ifdef BRANCH_FLUSH_EN
    if (m_ctrl[1]) m_ir = 32'd0;
    else if (E) m_ir = instr_in;
`else
    if (E) m_ir = instr_in;
`endif
    if (E) m_pc = next_pc;
    #1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [2:0]  cls;
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1:    cls = 3'b000;
      2:       cls = 3'b001;
      3, 4:    cls = 3'b010;
      5:       cls = 3'b011;
      6, 7:    cls = 3'b101;
      8:       cls = 3'($urandom_range(0, 7));
      default: cls = 3'b101;
    endcase
    w[27:25] = cls;
    if ($urandom_range(0, 19) == 0) w = 32'd0;
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #6;
    chk("reset_instr_out", {32'd0, instr_out}, 64'd0);
    chk("reset_Next_PC", {32'd0, Next_PC}, 64'd0);
    chk("reset_ctrl", {59'd0, ALU_OP, RF_E}, 64'd0);
    #16 reset = 1'b1;
    @(posedge clk); #1;

    // ADD r1,r2,r3
    setup(32'hE0821003, 32'h0000_0104, 1, 0, 4'b0000); tick();
    setup(32'h1111_1111, 32'h0000_0108, 0, 0, 4'b0000); #3;
    chk("add_alu", {60'd0, ALU_OP}, 64'h4);
    chk("add_am_rfe_scc", {60'd0, ID_AM, RF_E, STORE_CC}, {60'd0, 2'b01, 1'b1, 1'b0});
    chk("add_regs", {52'd0, instr_i19_i16, instr_i15_i12, instr_i3_i0}, 64'h213);
    tick();

    // LDR r1,[r2,#4]
    setup(32'hE5921004, 32'h0000_0110, 1, 0, 4'b0000); tick();
    setup(32'h0, 32'h0, 0, 0, 4'b0000); #3;
    chk("ldr_ctrl", {55'd0, ID_LOAD, ID_MEM_E, ID_MEM_WRITE, ID_MEM_SIZE, ALU_OP, RF_E},
        {55'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 1'b1});
    chk("ldr_am", {62'd0, ID_AM}, {62'd0, 2'b10});
    tick();

    // CMP r1,#0, then the same with a bubble
    setup(32'hE3510000, 32'h0000_0120, 1, 0, 4'b0000); tick();
    setup(32'h0, 32'h0, 0, 0, 4'b0000); #3;
    chk("cmp_ctrl", {56'd0, ALU_OP, STORE_CC, RF_E, ID_AM}, {56'd0, 4'b1010, 1'b1, 1'b0, 2'b00});
    tick();
    setup(32'h0, 32'h0, 0, 1, 4'b0000); #3;
    chk("cmp_bubble", {46'd0, ALU_OP, ID_AM, ID_LOAD, ID_MEM_WRITE, ID_MEM_SIZE, ID_MEM_E,
                       STORE_CC, RF_E, ID_B, ID_BL, Branched, EX_BL_instr}, 64'd0);
    chk("cmp_bubble_taps", {32'd0, instr_out}, {32'd0, 32'hE3510000});
    tick();

    // BEQ taken / not taken
    setup(32'h0A000002, 32'h0000_0130, 1, 0, 4'b0100); tick();
    setup(32'hE0821003, 32'h0000_0134, 0, 0, 4'b0100); #3;
    chk("beq_taken", {63'd0, Branched}, 64'd1);
    tick();
    setup(32'h0A000002, 32'h0000_0140, 1, 0, 4'b0000); tick();
    setup(32'hE0821003, 32'h0000_0144, 0, 0, 4'b0000); #3;
    chk("beq_not_taken", {63'd0, Branched}, 64'd0);
    tick();

    // BL always, then flush/delay-slot behaviour
    setup(32'hEB000005, 32'h0000_0150, 1, 0, 4'b0000); tick();
    setup(32'hE0821003, 32'h0000_0154, 0, 0, 4'b0000); #3;
    chk("bl_decode", {62'd0, ID_BL, EX_BL_instr}, 64'd3);
    tick();
    setup(32'hE0821003, 32'h0000_0158, 0, 0, 4'b0000); #3;
`ifdef BRANCH_FLUSH_EN
    chk("bl_flush", {32'd0, instr_out}, 64'd0);
`else
    chk("bl_delay_slot", {32'd0, instr_out}, {32'd0, 32'hEB000005});
`endif
    tick();

    // Stall: three edges with E=0 and changing inputs
    setup(32'hE0821003, 32'h0000_0200, 1, 0, 4'b0000); tick();
    for (int unsigned i = 0; i < 3; i++) begin
      setup($urandom, $urandom, 0, 0, 4'b0000); tick();
    end
    setup(32'h0, 32'h0, 0, 0, 4'b0000); #3;
    chk("stall_instr", {32'd0, instr_out}, {32'd0, 32'hE0821003});
    chk("stall_pc", {32'd0, Next_PC}, {32'd0, 32'h0000_0200});
    tick();

    // Randomized traffic
    for (int unsigned i = 0; i < 400; i++) begin
      setup(rand_instr(), $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
            4'($urandom));
      tick();
    end

    // Asynchronous reset mid-cycle
    #1 reset = 1'b0; E = 1'b0;
    #1;
    chk("async_reset_instr", {32'd0, instr_out}, 64'd0);
    chk("async_reset_pc", {32'd0, Next_PC}, 64'd0);
    m_ir = '0; m_pc = '0;
    @(posedge clk); #3 reset = 1'b1;
    @(posedge clk); #1;
    for (int unsigned i = 0; i < 50; i++) begin
      setup(rand_instr(), $urandom, 1'($urandom), 1'($urandom), 4'($urandom));
      tick();
    end

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
